hazard_bubble_ctrl: RTL and testbench

- Parametrised, registered successor to the combinational hazard bubble mux.
- Owns the ID/EX control-field register (EX/MEM/WB groups) and inserts bubbles by zeroing those fields.
- Handles multi-cycle load-use stalls and multi-cycle branch flushes, and drives PC/IF-ID write enables and the IF-ID flush.
- Keeps a saturating bubble statistics counter. Sits between the main control unit/hazard detector and the ID/EX pipeline register.

---
 rtl/hazard_bubble_ctrl.sv | 149 ++++++++++++++
 tb/tb_hazard_bubble_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_bubble_ctrl.sv
// Registered ID/EX control-field stage with bubble insertion for multi-cycle
// load-use stalls and branch flushes, plus a saturating bubble counter.
module hazard_bubble_ctrl #(
   parameter int EX_W         = 4,
   parameter int MEM_W        = 3,
   parameter int WB_W         = 2,
   parameter int STALL_CYCLES = 1,
   parameter int FLUSH_CYCLES = 1,
   parameter int STAT_W       = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              hazard,
   input  logic              flush,
   input  logic [EX_W-1:0]   ex_in,
   input  logic [MEM_W-1:0]  mem_in,
   input  logic [WB_W-1:0]   wb_in,
   output logic [EX_W-1:0]   ex_out,
   output logic [MEM_W-1:0]  mem_out,
   output logic [WB_W-1:0]   wb_out,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              ifid_flush,
   output logic              bubble_active,
   output logic [STAT_W-1:0] bubble_count
);

   if (STALL_CYCLES < 1 || STALL_CYCLES > 15) begin : g_bad_stall_cycles
      $error("hazard_bubble_ctrl: STALL_CYCLES must be in 1..15");
   end
   if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
      $error("hazard_bubble_ctrl: FLUSH_CYCLES must be in 1..15");
   end
   if (EX_W < 1 || MEM_W < 1 || WB_W < 1 || STAT_W < 1) begin : g_bad_widths
      $error("hazard_bubble_ctrl: all widths must be at least 1");
   end

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_STALL = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   localparam logic [3:0] STALL_RELOAD = 4'(STALL_CYCLES - 1);
   localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
   localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

   logic [1:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [EX_W-1:0]   ex_q, ex_d;
   logic [MEM_W-1:0]  mem_q, mem_d;
   logic [WB_W-1:0]   wb_q, wb_d;
   logic [STAT_W-1:0] count_q, count_d;
   logic              load_bubble;

   // A flush always wins, in any state, and restarts the flush window.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      load_bubble = 1'b0;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      if (flush) begin
         load_bubble = 1'b1;
         ifid_flush  = 1'b1;
         if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_RELOAD;
         end else begin
            state_d = ST_RUN;
            cnt_d   = 4'd0;
         end
      end else begin
         case (state_q)
            ST_RUN: begin
               if (hazard) begin
                  load_bubble = 1'b1;
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  if (STALL_CYCLES > 1) begin
                     state_d = ST_STALL;
                     cnt_d   = STALL_RELOAD;
                  end
               end
            end
            ST_STALL: begin
               load_bubble = 1'b1;
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               cnt_d       = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d = ST_RUN;
               end
            end
            ST_FLUSH: begin
               load_bubble = 1'b1;
               ifid_flush  = 1'b1;
               cnt_d       = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d = ST_RUN;
               end
            end
            default: begin
               state_d = ST_RUN;
               cnt_d   = 4'd0;
            end
         endcase
      end
   end

   always_comb begin
      ex_d    = ex_in;
      mem_d   = mem_in;
      wb_d    = wb_in;
      count_d = count_q;
      if (load_bubble) begin
         ex_d  = '0;
         mem_d = '0;
         wb_d  = '0;
         if (count_q != STAT_MAX) begin
            count_d = count_q + STAT_W'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_RUN;
         cnt_q   <= 4'd0;
         ex_q    <= '0;
         mem_q   <= '0;
         wb_q    <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ex_q    <= ex_d;
         mem_q   <= mem_d;
         wb_q    <= wb_d;
         count_q <= count_d;
      end
   end

   assign ex_out        = ex_q;
   assign mem_out       = mem_q;
   assign wb_out        = wb_q;
   assign bubble_count  = count_q;
   assign bubble_active = load_bubble & ~reset;

endmodule

// File: tb/tb_hazard_bubble_ctrl.sv
// Bench for hazard_bubble_ctrl: directed literal checks followed by random
// hazard/flush/reset traffic compared against a bubble-window model.
module tb_hazard_bubble_ctrl;

   localparam int STALL_N = 3;
   localparam int FLUSH_N = 2;
   localparam int SAT_MAX = 255;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       hazard = 1'b0;
   logic       flush = 1'b0;
   logic [3:0] ex_in = '0;
   logic [2:0] mem_in = '0;
   logic [1:0] wb_in = '0;
   logic [3:0] ex_out;
   logic [2:0] mem_out;
   logic [1:0] wb_out;
   logic       pc_write, ifid_write, ifid_flush, bubble_active;
   logic [7:0] bubble_count;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   hazard_bubble_ctrl #(
      .EX_W(4), .MEM_W(3), .WB_W(2),
      .STALL_CYCLES(STALL_N), .FLUSH_CYCLES(FLUSH_N), .STAT_W(8)
   ) dut (
      .clock(clk), .reset(rst), .hazard(hazard), .flush(flush),
      .ex_in(ex_in), .mem_in(mem_in), .wb_in(wb_in),
      .ex_out(ex_out), .mem_out(mem_out), .wb_out(wb_out),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .bubble_active(bubble_active), .bubble_count(bubble_count)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: remaining bubbles of each kind still owed after this cycle.
   int         stall_left = 0;
   int         flush_left = 0;
   int         m_count = 0;
   logic [3:0] m_ex = '0;
   logic [2:0] m_mem = '0;
   logic [1:0] m_wb = '0;
   bit         m_ok = 0;

   // 0 = pass-through, 1 = stall bubble, 2 = flush bubble
   function automatic int kind_now();
      if (flush) return 2;
      if (flush_left > 0) return 2;
      if (stall_left > 0) return 1;
      if (hazard) return 1;
      return 0;
   endfunction

   always @(posedge clk) begin
      int k;
      if (rst) begin
         stall_left = 0;
         flush_left = 0;
         m_count    = 0;
         m_ex = '0; m_mem = '0; m_wb = '0;
         m_ok = 1;
      end else begin
         k = kind_now();
         if (k != 0) begin
            m_ex = '0; m_mem = '0; m_wb = '0;
            if (m_count < SAT_MAX) m_count++;
         end else begin
            m_ex = ex_in; m_mem = mem_in; m_wb = wb_in;
         end
         if (flush) begin
            flush_left = FLUSH_N - 1;
            stall_left = 0;
         end else if (flush_left > 0) begin
            flush_left--;
         end else if (stall_left > 0) begin
            stall_left--;
         end else if (hazard) begin
            stall_left = STALL_N - 1;
         end
      end
   end

   always @(negedge clk) begin
      int k;
      if (m_ok && !rst) begin
         k = kind_now();
         chk("m_ex_out", int'(ex_out), int'(m_ex));
         chk("m_mem_out", int'(mem_out), int'(m_mem));
         chk("m_wb_out", int'(wb_out), int'(m_wb));
         chk("m_pc_write", int'(pc_write), int'(k != 1));
         chk("m_ifid_write", int'(ifid_write), int'(k != 1));
         chk("m_ifid_flush", int'(ifid_flush), int'(k == 2));
         chk("m_bubble_active", int'(bubble_active), int'(k != 0));
         chk("m_bubble_count", int'(bubble_count), m_count);
      end
   end

   // One cycle with the given inputs; returns at the following negedge.
   task automatic drive(input logic r, input logic h, input logic f);
      @(posedge clk);
      #1;
      rst = r; hazard = h; flush = f;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; hazard = 1'b1; flush = 1'b1;
      ex_in = 4'hF; mem_in = 3'h7; wb_in = 2'h3;
      drive(1, 1, 1);
      drive(1, 1, 1);
      ex_in = 4'hA; mem_in = 3'h5; wb_in = 2'h3;
      drive(0, 0, 0);
      chk("reset_ex_out", int'(ex_out), 0);
      chk("reset_mem_out", int'(mem_out), 0);
      chk("reset_count", int'(bubble_count), 0);
      chk("reset_pc_write", int'(pc_write), 1);
      chk("reset_ifid_flush", int'(ifid_flush), 0);
      drive(0, 0, 0);
      chk("pass_ex", int'(ex_out), 10);
      chk("pass_mem", int'(mem_out), 5);
      chk("pass_wb", int'(wb_out), 3);
      chk("pass_count", int'(bubble_count), 0);

      drive(0, 1, 0);
      chk("stall0_pc_write", int'(pc_write), 0);
      chk("stall0_ifid_write", int'(ifid_write), 0);
      drive(0, 0, 0);
      chk("stall1_pc_write", int'(pc_write), 0);
      chk("stall1_ex_out", int'(ex_out), 0);
      drive(0, 0, 0);
      chk("stall2_pc_write", int'(pc_write), 0);
      drive(0, 0, 0);
      chk("stall_done_pc_write", int'(pc_write), 1);
      chk("stall_done_bubble", int'(bubble_active), 0);
      chk("stall_count", int'(bubble_count), 3);
      drive(0, 0, 0);
      chk("after_stall_ex", int'(ex_out), 10);

      drive(0, 1, 0);
      drive(0, 0, 0);
      drive(0, 0, 1);
      chk("abort_ifid_flush", int'(ifid_flush), 1);
      chk("abort_pc_write", int'(pc_write), 1);
      drive(0, 0, 0);
      chk("abort_tail_flush", int'(ifid_flush), 1);
      chk("abort_tail_bubble", int'(bubble_active), 1);
      drive(0, 0, 0);
      chk("abort_done_bubble", int'(bubble_active), 0);
      chk("abort_count", int'(bubble_count), 7);

      drive(0, 1, 1);
      chk("both_ifid_flush", int'(ifid_flush), 1);
      chk("both_pc_write", int'(pc_write), 1);
      chk("both_ifid_write", int'(ifid_write), 1);
      drive(0, 0, 0);
      chk("both_no_stall_pc", int'(pc_write), 1);
      chk("both_tail_flush", int'(ifid_flush), 1);
      drive(0, 0, 0);
      chk("both_count", int'(bubble_count), 9);

      repeat (260) drive(0, 0, 1);
      chk("sat_count", int'(bubble_count), 255);
      repeat (5) drive(0, 1, 1);
      chk("sat_hold", int'(bubble_count), 255);
      drive(0, 0, 0);

      for (int i = 0; i < 3000; i++) begin
         ex_in  = 4'($urandom_range(0, 15));
         mem_in = 3'($urandom_range(0, 7));
         wb_in  = 2'($urandom_range(0, 3));
         drive(logic'($urandom_range(0, 199) == 0),
               logic'($urandom_range(0, 3) == 0),
               logic'($urandom_range(0, 7) == 0));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
